// File: rtl/s_verify.sv
// s_verify: read-only checker for the 256-byte S memory.
// Sweeps addresses 0..DEPTH-1 through the shared s_mem read port and checks
// each entry against the identity fill (s[i] == i). Define S_VERIFY_PERM_EN
// to also build a permutation check (each byte value seen exactly once).
// Never writes: wren and wrdata are tied to zero.
module s_verify #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_mode,
  output logic              o_rdy,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wrdata,
  output logic              o_wren,
  input  logic [DATA_W-1:0] i_q,
  output logic              o_pass,
  output logic [ADDR_W-1:0] o_mismatch_addr,
  output logic [DATA_W-1:0] o_mismatch_data,
  output logic [ADDR_W:0]   o_err_count
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_t;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic              r_rdy;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_idx_d;    // address issued last cycle, pairs with i_q
  logic              r_first;    // first READ cycle: no read data yet
  logic              r_pass;
  logic [ADDR_W-1:0] r_mm_addr;
  logic [DATA_W-1:0] r_mm_data;
  logic [ADDR_W:0]   r_err_count;

  logic              w_cmp;
  logic              w_perm;
  logic              w_fail;
  logic              w_id_fail;
  logic              w_perm_fail;
  logic [ADDR_W:0]   w_err_next;

`ifdef S_VERIFY_PERM_EN
  logic              r_mode;
  logic [DEPTH-1:0]  r_bitmap;

  // Permutation failure: value already seen, or out of the bitmap's range
  always_comb begin
    w_perm      = r_mode;
    w_perm_fail = 1'b1;
    if (32'(i_q) < DEPTH) begin
      w_perm_fail = r_bitmap[i_q];
    end
  end
`else
  logic w_unused_mode;

  // Mode is ignored in the identity-only build
  always_comb begin
    w_perm        = 1'b0;
    w_perm_fail   = 1'b0;
    w_unused_mode = i_mode;
  end
`endif

  // Compare decision and saturating error count for the current read beat
  always_comb begin
    w_cmp      = ((r_state == StRead) && !r_first) || (r_state == StDrain);
    w_id_fail  = (i_q != DATA_W'(r_idx_d));
    w_fail     = w_cmp && (w_perm ? w_perm_fail : w_id_fail);
    w_err_next = r_err_count;
    if (w_fail && !(&r_err_count)) begin
      w_err_next = r_err_count + (ADDR_W + 1)'(1);
    end
  end

  // Scan FSM with registered outputs and result capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_rdy       <= 1'b1;
      r_addr      <= '0;
      r_idx_d     <= '0;
      r_first     <= 1'b0;
      r_pass      <= 1'b0;
      r_mm_addr   <= '0;
      r_mm_data   <= '0;
      r_err_count <= '0;
`ifdef S_VERIFY_PERM_EN
      r_mode      <= 1'b0;
      r_bitmap    <= '0;
`endif
    end else begin
      r_idx_d <= r_addr;

      if (w_cmp) begin
        r_err_count <= w_err_next;
        // Only the first failing entry is recorded
        if (w_fail && (r_err_count == '0)) begin
          r_mm_addr <= r_idx_d;
          r_mm_data <= i_q;
        end
`ifdef S_VERIFY_PERM_EN
        if (32'(i_q) < DEPTH) begin
          r_bitmap[i_q] <= 1'b1;
        end
`endif
      end

      case (r_state)
        StIdle: begin
          if (i_en) begin
            r_state     <= StRead;
            r_rdy       <= 1'b0;
            r_addr      <= '0;
            r_first     <= 1'b1;
            r_pass      <= 1'b0;
            r_mm_addr   <= '0;
            r_mm_data   <= '0;
            r_err_count <= '0;
`ifdef S_VERIFY_PERM_EN
            r_mode      <= i_mode;
            r_bitmap    <= '0;
`endif
          end
        end
        StRead: begin
          r_first <= 1'b0;
          if (r_addr == LastAddr) begin
            r_state <= StDrain;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        StDrain: begin
          r_state <= StIdle;
          r_rdy   <= 1'b1;
          r_addr  <= '0;
          r_pass  <= (w_err_next == '0);
        end
        default: begin
          r_state <= StIdle;
          r_rdy   <= 1'b1;
          r_addr  <= '0;
        end
      endcase
    end
  end

  assign o_rdy           = r_rdy;
  assign o_addr          = r_addr;
  assign o_wrdata        = '0;
  assign o_wren          = 1'b0;
  assign o_pass          = r_pass;
  assign o_mismatch_addr = r_mm_addr;
  assign o_mismatch_data = r_mm_data;
  assign o_err_count     = r_err_count;

endmodule

// File: doc/s_verify.md
Name: s_verify

Overview:
- Read-side companion to the S-memory initialiser: scans the 256-byte S memory through its single read port and checks the contents.
- Default check is the identity fill, s[i] == i. Optional permutation mode checks that S holds each byte value exactly once (post-KSA sanity).
- Sits beside init on the same s_mem port. Port ownership is muxed at top level by rdy; this block drives wren = 0 at all times.
- Uses the codebase's en/rdy request protocol.

Parameters:
- DEPTH, 256, number of S entries scanned, addresses 0..DEPTH-1.
- ADDR_W, 8, address width; DEPTH must be <= 2**ADDR_W.
- DATA_W, 8, memory word width.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, start request; honoured only while rdy = 1.
- mode, input, 1, 0 = identity check, 1 = permutation check.
- rdy, output, 1, high when idle and results are stable.
- addr, output, ADDR_W, s_mem address.
- wrdata, output, DATA_W, constant 0.
- wren, output, 1, constant 0.
- q, input, DATA_W, s_mem read data; valid one cycle after addr is presented.
- pass, output, 1, result of the last completed scan.
- mismatch_addr, output, ADDR_W, address of the first failing entry.
- mismatch_data, output, DATA_W, data read at that address.
- err_count, output, ADDR_W+1, number of failing entries.

Behaviour:
- Reset values: rdy = 1, addr = 0, pass = 0, mismatch_addr = 0, mismatch_data = 0, err_count = 0, state IDLE, permutation bitmap cleared.
- States are IDLE, READ and DRAIN.
- IDLE:
  - rdy = 1.
  - en = 1 at an edge causes: latch mode; clear err_count, mismatch_*, bitmap; set pass = 0; addr = 0; go to READ; rdy falls at that edge.
- READ:
  - Lasts DEPTH cycles. addr presents 0, 1, ..., DEPTH-1, one per cycle.
  - On every cycle after the first, compare q against the index issued in the previous cycle (idx_d, one-cycle delayed copy of addr).
  - After DEPTH-1 is issued, go to DRAIN. addr is not incremented past DEPTH-1 (no wrap to 0).
- DRAIN:
  - One cycle; compares the entry for DEPTH-1.
  - Next edge: pass = (err_count_final == 0), rdy = 1, state IDLE, addr = 0.
- Latency: rdy is low for exactly DEPTH+1 cycles after the accepting edge (257 with defaults).
- Identity check: failure when q != idx_d[DATA_W-1:0].
- Permutation check: failure when bitmap[q] is already set; bitmap[q] is set on every compare.
  - With DEPTH = 256 and 8-bit data, zero failures implies a full permutation.
- Any failure increments err_count (saturating at 2**(ADDR_W+1)-1).
- On the first failure only, mismatch_addr = idx_d and mismatch_data = q; later failures leave them unchanged.
- pass, mismatch_* and err_count hold their values in IDLE until the next accepted en.
- en while rdy = 0 is ignored, with no queuing.
- en held high in IDLE restarts immediately after completion; rdy is high for that one cycle.
- mode changes after acceptance have no effect.
- rst asserted in any state wins over en. All outputs return to reset values at that edge and the scan is abandoned; partial results are discarded.
- wren and wrdata are always 0, including during reset.

Optional Feature:
- Macro: S_VERIFY_PERM_EN.
- Defined: permutation mode and the DEPTH-bit bitmap are built as described above.
- Undefined: no bitmap logic; mode is ignored and treated as 0 (identity check); the mode port remains present.

Test Plan:
- Identity memory, s[i] = i for i = 0..255; reset, then pulse en with mode = 0 -> addr sweeps 0..255 one per cycle, rdy low 257 cycles; then pass = 1, err_count = 0, wren never 1.
- Identity memory with s[0x5A] = 0x00 and s[0xC3] = 0xFF; mode = 0 -> pass = 0, err_count = 2, mismatch_addr = 0x5A, mismatch_data = 0x00.
- Memory s[i] = 255 - i, mode = 1 (S_VERIFY_PERM_EN defined) -> pass = 1, err_count = 0. Same run with mode = 0 -> err_count = 256, mismatch_addr = 0x00, mismatch_data = 0xFF.
- Permutation with s[0x10] overwritten to 0x05; mode = 1 -> pass = 0, err_count = 1, mismatch_addr = 0x10, mismatch_data = 0x05.
- Assert rst for one cycle at scan cycle 100 -> next edge rdy = 1, addr = 0, err_count = 0, pass = 0. A fresh en on an identity memory then passes with full 257-cycle latency.
- Pulse en again at scan cycle 50 and toggle mode mid-scan -> no restart; completion still at cycle 257 with results for the original mode.
